// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider: FSM state encoding
// and the default operand width.
package div_pkg;
  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] SUB   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of seq_divider. The master drives the operands and
// start; the slave (the divider) returns results and status.
interface seq_divider_if #(parameter int WIDTH = div_pkg::DEF_WIDTH);
  logic             St;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (
    output St, Dividend, Divisor,
    input  Quotient, Remainder, Busy, Done, DivZero
  );

  modport slave (
    input  St, Dividend, Divisor,
    output Quotient, Remainder, Busy, Done, DivZero
  );
endinterface

// File: rtl/div_control.sv
// Divider sequencer: IDLE/SHIFT/SUB/DONE FSM plus iteration counter, issuing
// load/shift/sub strobes. DIVIDER_DIVZERO_DETECT_EN adds the zero-divisor bypass.
module div_control import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic Clk,
  input  logic Reset,
  input  logic st,
`ifdef DIVIDER_DIVZERO_DETECT_EN
  input  logic div_zero,
  output logic dz_load,
`endif
  output logic load,
  output logic shift,
  output logic sub,
  output logic busy,
  output logic done
);
  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(WIDTH - 1);

  logic [1:0]    state, state_nx;
  logic [KW-1:0] k;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift    = 1'b0;
    sub      = 1'b0;
`ifdef DIVIDER_DIVZERO_DETECT_EN
    dz_load  = 1'b0;
`endif
    case (state)
      IDLE: if (st) begin
`ifdef DIVIDER_DIVZERO_DETECT_EN
        if (div_zero) begin
          dz_load  = 1'b1;
          state_nx = DONE;
        end else begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
`else
        load     = 1'b1;
        state_nx = SHIFT;
`endif
      end
      SHIFT: begin
        shift    = 1'b1;
        state_nx = SUB;
      end
      SUB: begin
        sub      = 1'b1;
        state_nx = (k == KLAST) ? DONE : SHIFT;
      end
      default: state_nx = IDLE;
    endcase
  end

  // K sits at zero whenever idle, so every accepted start begins from 0.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) k <= '0;
      else if (sub)      k <= k + 1'b1;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per SHIFT+SUB pair.
// Optional zero-divisor short cut under DIVIDER_DIVZERO_DETECT_EN.
module seq_divider import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          Clk,
  input  logic          Reset,
  seq_divider_if.slave  bus
);
  logic [WIDTH-1:0] quo, rem, dvsr, rem_sub;
  logic             rc, ge;
  logic             load, shift, sub, busy, done;
  logic [WIDTH:0]   rem_ext;

`ifdef DIVIDER_DIVZERO_DETECT_EN
  logic dz_load, dz;

  div_control #(.WIDTH(WIDTH)) u_ctrl (
    .Clk(Clk), .Reset(Reset), .st(bus.St),
    .div_zero(bus.Divisor == '0), .dz_load(dz_load),
    .load(load), .shift(shift), .sub(sub), .busy(busy), .done(done)
  );
`else
  div_control #(.WIDTH(WIDTH)) u_ctrl (
    .Clk(Clk), .Reset(Reset), .st(bus.St),
    .load(load), .shift(shift), .sub(sub), .busy(busy), .done(done)
  );
`endif

  // rc keeps the bit shifted out of rem, so the partial remainder is WIDTH+1
  // bits wide and divisors with the MSB set still divide correctly.
  assign rem_ext = {rc, rem};
  assign ge      = (rem_ext >= {1'b0, dvsr});
  assign rem_sub = rem - dvsr;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      quo  <= '0;
      rem  <= '0;
      rc   <= 1'b0;
      dvsr <= '0;
    end else if (load) begin
      quo  <= bus.Dividend;
      rem  <= '0;
      rc   <= 1'b0;
      dvsr <= bus.Divisor;
`ifdef DIVIDER_DIVZERO_DETECT_EN
    end else if (dz_load) begin
      quo  <= '1;
      rem  <= bus.Dividend;
      rc   <= 1'b0;
      dvsr <= '0;
`endif
    end else if (shift) begin
      {rc, rem, quo} <= {rem, quo, 1'b0};
    end else if (sub) begin
      // A taken or skipped subtract both leave the remainder below dvsr.
      rc <= 1'b0;
      if (ge) begin
        rem    <= rem_sub;
        quo[0] <= 1'b1;
      end
    end
  end

`ifdef DIVIDER_DIVZERO_DETECT_EN
  always_ff @(posedge Clk) begin
    if (!Reset)       dz <= 1'b0;
    else if (load)    dz <= 1'b0;
    else if (dz_load) dz <= 1'b1;
  end
  assign bus.DivZero = dz;
`else
  assign bus.DivZero = 1'b0;
`endif

  assign bus.Quotient  = quo;
  assign bus.Remainder = rem;
  assign bus.Busy      = busy;
  assign bus.Done      = done;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// compared against plain / and % arithmetic.
module tb_seq_divider;
  import div_pkg::*;
  localparam int W = DEF_WIDTH;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  int   n_chk = 0, n_fail = 0, done_cnt = 0;

  always #5 Clk = ~Clk;

  seq_divider_if #(.WIDTH(W)) bus();
  seq_divider #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always @(posedge Clk) begin
    #2;
    if (bus.Done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output int lat);
    lat = 2 * W + 1;
    dz  = 1'b0;
    if (dv == 0) begin
      q = '1;
      r = dd;
`ifdef DIVIDER_DIVZERO_DETECT_EN
      dz  = 1'b1;
      lat = 1;
`endif
    end else begin
      q = dd / dv;
      r = dd % dv;
    end
  endfunction

  // st_at/rst_at: edge number (accept edge = 1) at which a stray start or a
  // reset is applied; 0 disables.
  task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input int st_at, input int rst_at);
    logic [W-1:0] eq, er;
    logic         edz;
    int           elat, n, d0;
    bit           aborted;
    model(dd, dv, eq, er, edz, elat);
    @(negedge Clk);
    bus.St = 1'b1; bus.Dividend = dd; bus.Divisor = dv;
    d0 = done_cnt;
    @(posedge Clk);
    n = 1;
    aborted = 1'b0;
    @(negedge Clk);
    bus.St = 1'b0; bus.Dividend = W'($urandom); bus.Divisor = W'($urandom);
    while (!bus.Done && !aborted && n < 4 * W) begin
      if (n + 1 == st_at) begin
        bus.St = 1'b1;
        bus.Dividend = W'($urandom);
        bus.Divisor  = W'($urandom_range(1, 2**W - 1));
      end
      if (n + 1 == rst_at) Reset = 1'b0;
      @(posedge Clk);
      n++;
      @(negedge Clk);
      bus.St = 1'b0;
      if (!Reset) begin
        aborted = 1'b1;
        Reset = 1'b1;
      end
    end
    if (aborted) begin
      chk("rst_quotient",  bus.Quotient,  0);
      chk("rst_remainder", bus.Remainder, 0);
      chk("rst_busy",      bus.Busy,      0);
      chk("rst_done",      bus.Done,      0);
      chk("rst_divzero",   bus.DivZero,   0);
      repeat (3 * W) @(negedge Clk);
      chk("rst_no_done", done_cnt - d0, 0);
    end else begin
      chk("latency",   n,             elat);
      chk("done",      bus.Done,      1);
      chk("quotient",  bus.Quotient,  eq);
      chk("remainder", bus.Remainder, er);
      chk("divzero",   bus.DivZero,   edz);
      chk("busy_done", bus.Busy,      1);
      @(negedge Clk);
      chk("done_pulse",  bus.Done,      0);
      chk("idle",        bus.Busy,      0);
      chk("hold_quot",   bus.Quotient,  eq);
      chk("hold_rem",    bus.Remainder, er);
      chk("done_count",  done_cnt - d0, 1);
    end
  endtask

  initial begin
    int n;
    logic [W-1:0] dd, dv;
    // Start requested during reset must lose to reset.
    bus.St = 1'b1; bus.Dividend = 8'd9; bus.Divisor = 8'd2;
    repeat (3) @(negedge Clk);
    chk("reset_quotient",  bus.Quotient,  0);
    chk("reset_remainder", bus.Remainder, 0);
    chk("reset_busy",      bus.Busy,      0);
    chk("reset_done",      bus.Done,      0);
    chk("reset_divzero",   bus.DivZero,   0);
    bus.St = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);

    run_div(8'd100, 8'd7, 0, 0);
    run_div(8'd255, 8'd1, 0, 0);
    run_div(8'd5,   8'd9, 0, 0);
    run_div(8'd37,  8'd0, 0, 0);
    run_div(8'd255, 8'd200, 0, 0);
    run_div(8'd0,   8'd3, 0, 0);
    run_div(8'd100, 8'd7, 5, 0);
    run_div(8'd100, 8'd7, 0, 6);
    run_div(8'd200, 8'd13, 0, 0);

    // St held high through DONE restarts on the first IDLE cycle.
    @(negedge Clk);
    bus.St = 1'b1; bus.Dividend = 8'd50; bus.Divisor = 8'd6;
    n = 0;
    while (!bus.Done && n < 4 * W) begin
      @(negedge Clk);
      n++;
    end
    chk("held_first_done", bus.Done, 1);
    chk("held_first_quot", bus.Quotient, 8);
    chk("held_first_rem",  bus.Remainder, 2);
    bus.Dividend = 8'd91; bus.Divisor = 8'd4;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (n == 2) bus.St = 1'b0;
    end while (!bus.Done && n < 4 * W);
    chk("held_latency", n, 2 * W + 2);
    chk("held_quot",    bus.Quotient, 22);
    chk("held_rem",     bus.Remainder, 3);

    repeat (20) begin
      dd = W'($urandom);
      dv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_div(dd, dv, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit %0d ns", 200000);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits.
REQ-002 Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Reset  input  1  SHALL be a synchronous, active-low reset sampled on rising Clk.
REQ-004 St  input  1  SHALL be the start request, sampled only in IDLE.
REQ-005 Dividend  input  WIDTH  SHALL be the unsigned dividend, captured when St is accepted.
REQ-006 Divisor  input  WIDTH  SHALL be the unsigned divisor, captured when St is accepted.
REQ-007 Quotient  output  WIDTH  SHALL be the quotient register.
REQ-008 Remainder  output  WIDTH  SHALL be the remainder register.
REQ-009 Busy  output  1  SHALL be high in every state except IDLE.
REQ-010 Done  output  1  SHALL be a one-cycle completion pulse.
REQ-011 DivZero  output  1  SHALL be the divide-by-zero flag.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, SHIFT, SUB, DONE.
REQ-013 IDLE: St=1 → load Dividend into Quotient, clear Remainder, latch Divisor, clear iteration counter K, clear DivZero, go to SHIFT; St=0 → stay and hold all results.
REQ-014 SHIFT: shift the {Remainder, Quotient} pair left by 1 with 0 into Quotient[0], then go to SUB.
REQ-015 SUB: if Remainder >= latched divisor, Remainder ← Remainder − divisor and Quotient[0] ← 1; increment K; go to DONE when K reaches WIDTH−1 before increment, else go to SHIFT.
REQ-016 The compare/subtract SHALL use a WIDTH+1-bit intermediate so no carry is lost.
REQ-017 DONE: Done=1 for exactly this cycle, then go to IDLE unconditionally.
REQ-018 Latency: Done SHALL be high in the cycle following the 2·WIDTH+1-th rising edge after the edge that accepted St (17 for WIDTH=8).
REQ-019 St asserted while Busy=1 SHALL be ignored and SHALL NOT affect the operation in progress.
REQ-020 St held high through DONE SHALL start a new division on the first IDLE cycle.
REQ-021 Quotient and Remainder SHALL hold their final values from DONE until the next accepted St.
REQ-022 Dividend/Divisor changes after acceptance SHALL NOT affect the result.

Reset
REQ-023 Reset=0 at a rising edge SHALL force IDLE and set Quotient=0, Remainder=0, K=0, Busy=0, Done=0, DivZero=0.
REQ-024 Reset mid-operation SHALL abort the division with no Done pulse.
REQ-025 Reset SHALL take priority over St in the same cycle.

Configuration
REQ-026 Macro DIVIDER_DIVZERO_DETECT_EN defined: a zero Divisor at St acceptance SHALL set DivZero=1, Quotient=all ones, Remainder=Dividend, and go directly to DONE (Done high after 1 edge).
REQ-027 Macro undefined: DivZero SHALL be constant 0 and a zero divisor SHALL run the normal 2·WIDTH iteration path (result Quotient=all ones, Remainder=Dividend).

Structure
REQ-028 Package div_pkg SHALL hold the state encoding constants (IDLE, SHIFT, SUB, DONE) and the default WIDTH.
REQ-029 The FSM and counter SHALL live in a sub-module div_control that drives load/shift/sub strobes to the datapath in seq_divider.

Verification
REQ-030 WIDTH=8, Dividend=100, Divisor=7, St pulse → Done after 17 edges, Quotient=14, Remainder=2.
REQ-031 Dividend=255, Divisor=1 → Quotient=255, Remainder=0; Dividend=5, Divisor=9 → Quotient=0, Remainder=5.
REQ-032 Dividend=37, Divisor=0 with macro → DivZero=1, Quotient=255, Remainder=37, Done after 1 edge; without macro → DivZero=0, same values after 17 edges.
REQ-033 St pulsed again at edge 5 of a busy division with different operands → ignored; first result unchanged, exactly one Done.
REQ-034 Reset=0 at edge 6 of a division → next cycle IDLE, all outputs 0, no Done; a new St then completes correctly.
